// File: rtl/sspim_reg_arb_if.sv
// Reg-bus bundle: two requester ports, the SPI master configuration port,
// and the arbiter status outputs.
interface sspim_reg_arb_if;
    logic        m0_cs, m0_wr, m0_lock;
    logic [7:0]  m0_addr;
    logic [31:0] m0_wdata;
    logic [3:0]  m0_be;
    logic [31:0] m0_rdata;
    logic        m0_ack, m0_err;

    logic        m1_cs, m1_wr, m1_lock;
    logic [7:0]  m1_addr;
    logic [31:0] m1_wdata;
    logic [3:0]  m1_be;
    logic [31:0] m1_rdata;
    logic        m1_ack, m1_err;

    logic        s_cs, s_wr;
    logic [7:0]  s_addr;
    logic [31:0] s_wdata;
    logic [3:0]  s_be;
    logic [31:0] s_rdata;
    logic        s_ack;

    logic        gnt_id, busy;

    // Environment side: requesters plus the SPI master responder.
    modport master (
        output m0_cs, m0_wr, m0_lock, m0_addr, m0_wdata, m0_be,
        input  m0_rdata, m0_ack, m0_err,
        output m1_cs, m1_wr, m1_lock, m1_addr, m1_wdata, m1_be,
        input  m1_rdata, m1_ack, m1_err,
        input  s_cs, s_wr, s_addr, s_wdata, s_be,
        output s_rdata, s_ack,
        input  gnt_id, busy
    );

    // Arbiter side.
    modport slave (
        input  m0_cs, m0_wr, m0_lock, m0_addr, m0_wdata, m0_be,
        output m0_rdata, m0_ack, m0_err,
        input  m1_cs, m1_wr, m1_lock, m1_addr, m1_wdata, m1_be,
        output m1_rdata, m1_ack, m1_err,
        output s_cs, s_wr, s_addr, s_wdata, s_be,
        input  s_rdata, s_ack,
        output gnt_id, busy
    );
endinterface

// File: rtl/sspim_reg_arb.sv
// Two-requester round-robin arbiter in front of the SPI master reg bus,
// with lock/hold support and a per-transfer ack timeout.
module sspim_reg_arb #(
    parameter int unsigned TMO_CYC = 255
) (
    input  logic          clk,
    input  logic          reset,
    sspim_reg_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, XFER, DONE, HOLD} state_t;

    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t      r_state, w_state_nxt;
    logic        r_last_gnt, r_gnt_id;
    logic        r_s_cs, r_s_wr;
    logic [7:0]  r_s_addr, r_tmo_cnt;
    logic [31:0] r_s_wdata;
    logic [3:0]  r_s_be;
    logic [1:0]  r_ack, r_err;
    logic [31:0] r_rdata0, r_rdata1;

    logic        w_grant, w_pick, w_xfer_end;
    logic [1:0]  w_cs, w_lock;
    logic [31:0] w_rdata_resp;

    assign w_cs   = {bus.m1_cs, bus.m0_cs};
    assign w_lock = {bus.m1_lock, bus.m0_lock};

    // A simultaneous ack wins over the timeout, so it is tested first.
    assign w_xfer_end   = bus.s_ack || (r_tmo_cnt == TMO_LAST);
    assign w_rdata_resp = !bus.s_ack ? 32'hFFFF_FFFF : (r_s_wr ? 32'h0 : bus.s_rdata);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_pick      = r_gnt_id;
        case (r_state)
            IDLE: begin
                if (|w_cs) begin
                    w_grant     = 1'b1;
                    w_pick      = (&w_cs) ? ~r_last_gnt : w_cs[1];
                    w_state_nxt = XFER;
                end
            end
            XFER: begin
                if (w_xfer_end) w_state_nxt = DONE;
            end
            DONE: begin
                w_state_nxt = w_lock[r_gnt_id] ? HOLD : IDLE;
            end
            HOLD: begin
                if (w_cs[r_gnt_id]) begin
                    w_grant     = 1'b1;
                    w_state_nxt = XFER;
                end else if (!w_lock[r_gnt_id]) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last_gnt <= 1'b1;
            r_gnt_id   <= 1'b0;
            r_s_cs     <= 1'b0;
            r_s_wr     <= 1'b0;
            r_s_addr   <= '0;
            r_s_wdata  <= '0;
            r_s_be     <= '0;
            r_tmo_cnt  <= '0;
            r_ack      <= '0;
            r_err      <= '0;
            r_rdata0   <= '0;
            r_rdata1   <= '0;
        end else begin
            r_ack <= '0;
            r_err <= '0;
            if (w_grant) begin
                r_gnt_id  <= w_pick;
                if (r_state == IDLE) r_last_gnt <= w_pick;
                r_s_cs    <= 1'b1;
                r_s_wr    <= w_pick ? bus.m1_wr    : bus.m0_wr;
                r_s_addr  <= w_pick ? bus.m1_addr  : bus.m0_addr;
                r_s_wdata <= w_pick ? bus.m1_wdata : bus.m0_wdata;
                r_s_be    <= w_pick ? bus.m1_be    : bus.m0_be;
                r_tmo_cnt <= '0;
            end else if (r_state == XFER) begin
                if (w_xfer_end) begin
                    r_s_cs          <= 1'b0;
                    r_ack[r_gnt_id] <= 1'b1;
                    r_err[r_gnt_id] <= !bus.s_ack;
                    if (r_gnt_id) r_rdata1 <= w_rdata_resp;
                    else          r_rdata0 <= w_rdata_resp;
                end else begin
                    r_tmo_cnt <= r_tmo_cnt + 8'd1;
                end
            end
        end
    end

    assign bus.s_cs     = r_s_cs;
    assign bus.s_wr     = r_s_wr;
    assign bus.s_addr   = r_s_addr;
    assign bus.s_wdata  = r_s_wdata;
    assign bus.s_be     = r_s_be;
    assign bus.m0_ack   = r_ack[0];
    assign bus.m0_err   = r_err[0];
    assign bus.m0_rdata = r_rdata0;
    assign bus.m1_ack   = r_ack[1];
    assign bus.m1_err   = r_err[1];
    assign bus.m1_rdata = r_rdata1;
    assign bus.gnt_id   = r_gnt_id;
    assign bus.busy     = (r_state != IDLE);
endmodule

// File: tb/tb_sspim_reg_arb.sv
// Randomized bench for sspim_reg_arb against a transaction-level model of
// round-robin service order, transfer length, response data and errors.
module tb_sspim_reg_arb;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_chk = 0;
    int   n_bad = 0;

    sspim_reg_arb_if bus ();

    sspim_reg_arb #(.TMO_CYC(TMO)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // model state
    int          last_gnt;
    logic        q_wr   [2];
    logic [7:0]  q_addr [2];
    logic [31:0] q_wd   [2];
    logic [3:0]  q_be   [2];
    logic [31:0] exp_rd [2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic get_ack(input int i);
        return (i == 0) ? bus.m0_ack : bus.m1_ack;
    endfunction

    function automatic logic get_err(input int i);
        return (i == 0) ? bus.m0_err : bus.m1_err;
    endfunction

    function automatic logic [31:0] get_rd(input int i);
        return (i == 0) ? bus.m0_rdata : bus.m1_rdata;
    endfunction

    task automatic set_cs(input int i, input logic v);
        if (i == 0) bus.m0_cs = v;
        else        bus.m1_cs = v;
    endtask

    task automatic rand_fields();
        for (int i = 0; i < 2; i++) begin
            q_wr[i]   = 1'($urandom_range(0, 1));
            q_addr[i] = 8'($urandom);
            q_wd[i]   = $urandom;
            q_be[i]   = 4'($urandom);
        end
    endtask

    task automatic drive_fields();
        bus.m0_wr = q_wr[0]; bus.m0_addr = q_addr[0]; bus.m0_wdata = q_wd[0]; bus.m0_be = q_be[0];
        bus.m1_wr = q_wr[1]; bus.m1_addr = q_addr[1]; bus.m1_wdata = q_wd[1]; bus.m1_be = q_be[1];
    endtask

    // Wait (bounded) for s_cs with random s_ack noise outside XFER.
    task automatic wait_scs(output int wt);
        wt = 0;
        do begin
            bus.s_ack   = 1'($urandom_range(0, 1));
            bus.s_rdata = $urandom;
            @(negedge clk);
            wt++;
        end while (!bus.s_cs && wt < 8);
    endtask

    // Slave response: ack on the lat-th cycle of s_cs (lat > TMO means never).
    task automatic do_xfer(input int lat, input logic [31:0] rd, input int who,
                           input bit drop, output int k);
        k = 0;
        while (bus.s_cs && k < TMO + 3) begin
            k++;
            chk("s_addr_hold", 32'(bus.s_addr), 32'(q_addr[who]));
            chk("s_wdata_hold", bus.s_wdata, q_wd[who]);
            bus.s_ack   = (k == lat);
            bus.s_rdata = rd;
            if (drop && k == 1) set_cs(who, 1'b0);
            @(negedge clk);
        end
        bus.s_ack = 1'($urandom_range(0, 1));
    endtask

    task automatic check_done(input int who, input int lat, input logic [31:0] rd, input int k);
        chk("xfer_len", 32'(k), 32'((lat > TMO) ? TMO : lat));
        exp_rd[who] = (lat > TMO) ? 32'hFFFF_FFFF : (q_wr[who] ? 32'h0 : rd);
        chk("ack_win", 32'(get_ack(who)), 32'd1);
        chk("err_win", 32'(get_err(who)), 32'(lat > TMO));
        chk("rdata_win", get_rd(who), exp_rd[who]);
        chk("ack_other", 32'(get_ack(1 - who)), 32'd0);
        chk("err_other", 32'(get_err(1 - who)), 32'd0);
        chk("busy_done", 32'(bus.busy), 32'd1);
    endtask

    task automatic run_round(input bit r0, input bit r1, input int lat_a, input int lat_b, input bit drop);
        bit          pend [2];
        int          n, win, lat, wt, k;
        logic [31:0] rd;
        pend[0] = r0;
        pend[1] = r1;
        drive_fields();
        bus.m0_lock = 1'b0;
        bus.m1_lock = 1'b0;
        bus.m0_cs   = r0;
        bus.m1_cs   = r1;
        n = 0;
        while (pend[0] || pend[1]) begin
            win      = (pend[0] && pend[1]) ? (1 - last_gnt) : (pend[0] ? 0 : 1);
            last_gnt = win;
            lat      = (n == 0) ? lat_a : lat_b;
            wait_scs(wt);
            chk("grant_lat", 32'(wt), (n == 0) ? 32'd1 : 32'd2);
            chk("gnt_id", 32'(bus.gnt_id), 32'(win));
            chk("s_wr", 32'(bus.s_wr), 32'(q_wr[win]));
            chk("s_be", 32'(bus.s_be), 32'(q_be[win]));
            rd = $urandom;
            do_xfer(lat, rd, win, drop, k);
            check_done(win, lat, rd, k);
            set_cs(win, 1'b0);
            pend[win] = 1'b0;
            n++;
        end
        @(negedge clk);
        bus.s_ack = 1'b0;
        chk("ack_pulse", 32'(bus.m0_ack | bus.m1_ack), 32'd0);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("rdata0_hold", bus.m0_rdata, exp_rd[0]);
        chk("rdata1_hold", bus.m1_rdata, exp_rd[1]);
    endtask

    task automatic lock_test();
        int wt, k;
        rand_fields();
        q_wr[1] = 1'b0;
        drive_fields();
        bus.m1_lock = 1'b1;
        bus.m1_cs   = 1'b1;
        last_gnt    = 1;
        wait_scs(wt);
        chk("lk_gnt1", 32'(bus.gnt_id), 32'd1);
        do_xfer(2, 32'h1234_5678, 1, 1'b0, k);
        check_done(1, 2, 32'h1234_5678, k);
        chk("lk_rdata", bus.m1_rdata, 32'h1234_5678);
        bus.m1_cs = 1'b0;
        bus.m0_cs = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("hold_scs", 32'(bus.s_cs), 32'd0);
            chk("hold_busy", 32'(bus.busy), 32'd1);
        end
        q_addr[1] = q_addr[1] ^ 8'h5A;
        q_wr[1]   = 1'b0;
        drive_fields();
        bus.m1_lock = 1'b0;
        bus.m1_cs   = 1'b1;
        @(negedge clk);
        chk("hold_regrant", 32'(bus.s_cs), 32'd1);
        chk("hold_gnt", 32'(bus.gnt_id), 32'd1);
        do_xfer(1, 32'hCAFE_0001, 1, 1'b0, k);
        check_done(1, 1, 32'hCAFE_0001, k);
        bus.m1_cs = 1'b0;
        last_gnt  = 0;
        wait_scs(wt);
        chk("lk_m0_lat", 32'(wt), 32'd2);
        chk("lk_m0_gnt", 32'(bus.gnt_id), 32'd0);
        do_xfer(1, 32'hBEEF_0002, 0, 1'b0, k);
        check_done(0, 1, 32'hBEEF_0002, k);
        bus.m0_cs = 1'b0;
        @(negedge clk);
        bus.s_ack = 1'b0;
        chk("lk_idle", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_s_cs"}, 32'(bus.s_cs), 32'd0);
        chk({tag, "_s_bus"}, {bus.s_addr, bus.s_be, 3'd0, bus.s_wr, 16'd0}, 32'd0);
        chk({tag, "_s_wdata"}, bus.s_wdata, 32'd0);
        chk({tag, "_acks"}, 32'({bus.m0_ack, bus.m0_err, bus.m1_ack, bus.m1_err}), 32'd0);
        chk({tag, "_rdata0"}, bus.m0_rdata, 32'd0);
        chk({tag, "_rdata1"}, bus.m1_rdata, 32'd0);
        chk({tag, "_gnt"}, 32'(bus.gnt_id), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        int wt;
        bit r0, r1;
        reset = 1'b1;
        bus.m0_cs = 1'b0; bus.m1_cs = 1'b0; bus.m0_lock = 1'b0; bus.m1_lock = 1'b0;
        bus.s_ack = 1'b0; bus.s_rdata = '0;
        rand_fields();
        drive_fields();
        last_gnt  = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        @(negedge clk);

        // tie after reset: m0, then m1, then m0 again
        rand_fields(); run_round(1, 1, 2, 2, 0);
        rand_fields(); run_round(1, 1, 1, 3, 0);

        // single write, ack on the 3rd cycle
        rand_fields();
        q_wr[0] = 1'b1; q_addr[0] = 8'h04; q_wd[0] = 32'h0000_00A5;
        run_round(1, 0, 3, 0, 0);

        // timeout, then ack exactly on the timeout cycle
        rand_fields(); q_wr[0] = 1'b0; run_round(1, 0, TMO + 1, 0, 0);
        rand_fields(); q_wr[1] = 1'b0; run_round(0, 1, TMO, 0, 0);

        lock_test();

        // reset in the 2nd XFER cycle
        rand_fields();
        drive_fields();
        bus.m0_cs = 1'b1;
        wait_scs(wt);
        bus.s_ack = 1'b0;
        @(negedge clk);
        chk("pre_rst_scs", 32'(bus.s_cs), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst_scs_drop", 32'(bus.s_cs), 32'd0);
        chk("rst_no_ack", 32'(bus.m0_ack), 32'd0);
        bus.m0_cs = 1'b0;
        @(negedge clk);
        check_reset_outputs("midrst");
        reset     = 1'b0;
        last_gnt  = 1;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
        @(negedge clk);
        chk("post_rst_busy", 32'(bus.busy), 32'd0);
        chk("post_rst_ack", 32'(bus.m0_ack), 32'd0);
        rand_fields(); run_round(1, 1, 1, 1, 0);

        for (int i = 0; i < 40; i++) begin
            rand_fields();
            r0 = 1'($urandom_range(0, 1));
            r1 = 1'($urandom_range(0, 1));
            if (!r0 && !r1) r0 = 1'b1;
            run_round(r0, r1, $urandom_range(1, TMO + 1), $urandom_range(1, TMO + 1),
                      1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/sspim_reg_arb.md
SSPIM_REG_ARB -- requirements
Module: sspim_reg_arb

Interface
REQ-001 SHALL have parameter TMO_CYC, default 255: maximum cycles in XFER waiting for s_ack before a timeout (range 1..255; the counter is 8-bit).
REQ-002 SHALL have port clk, input, 1: single clock; all state sampled on the rising edge.
REQ-003 SHALL have port reset, input, 1: reset is asynchronous and active-high.
REQ-004 SHALL have ports m0_cs/m0_wr, input, 1 each: requester 0 select and write strobe (write = 1, read = 0).
REQ-005 SHALL have ports m0_addr[7:0], m0_wdata[31:0] and m0_be[3:0], input: requester 0 address, write data and byte enables.
REQ-006 SHALL have port m0_lock, input, 1: requester 0 asks to keep the grant after the current transfer.
REQ-007 SHALL have ports m0_rdata[31:0], m0_ack (1) and m0_err (1), output: requester 0 read data, one-cycle acknowledge, and timeout error flag.
REQ-008 SHALL provide an identical port set m1_* for requester 1.
REQ-009 SHALL have outputs s_cs, s_wr, s_addr[7:0], s_wdata[31:0] and s_be[3:0]: the registered reg bus toward the SPI master configuration port.
REQ-010 SHALL have inputs s_rdata[31:0] and s_ack (1): the SPI master reg bus response.
REQ-011 SHALL have outputs gnt_id (1, number of the owning requester) and busy (1, high whenever state != IDLE).

Function
REQ-012 SHALL implement the states IDLE, XFER, DONE and HOLD.
REQ-013 IDLE: if exactly one mN_cs=1, that requester SHALL be granted; on the same edge the state moves to XFER and gnt_id:=N.
REQ-014 IDLE with both cs=1: the grant SHALL go to the requester != last_gnt (round-robin); last_gnt:=winner.
REQ-015 On the grant edge, the winner's wr/addr/wdata/be SHALL be captured into s_*, and s_cs:=1; s_cs therefore rises 1 cycle after the request is sampled.
REQ-016 XFER: s_* SHALL be held constant; the 8-bit tmo_cnt SHALL increment each cycle starting at 0.
REQ-017 XFER with s_ack=1: s_cs:=0, mN_rdata:=s_rdata (wr=1 gives 0), mN_ack:=1, mN_err:=0, and the state moves to DONE.
REQ-018 XFER with tmo_cnt==TMO_CYC-1 and s_ack=0: s_cs:=0, mN_ack:=1, mN_err:=1, mN_rdata:=32'hFFFF_FFFF, and the state moves to DONE.
REQ-019 s_ack together with the timeout SHALL resolve as a normal ack, with no error.
REQ-020 DONE: mN_ack/mN_err SHALL be high for exactly this 1 cycle; cs is ignored in DONE.
REQ-021 DONE exit: the state SHALL move to HOLD if mN_lock=1, else to IDLE.
REQ-022 mN_rdata SHALL hold its value until the next ack to that requester.
REQ-023 HOLD: only the owner's cs SHALL be accepted; owner cs=1 leads to XFER with the same capture as REQ-015, and last_gnt is unchanged.
REQ-024 HOLD with owner cs=0 and lock=0 SHALL return to IDLE; the other requester's cs SHALL be ignored while in HOLD.
REQ-025 A non-granted requester SHALL see ack=0 and err=0 and its request stays pending; no request is dropped.
REQ-026 A requester dropping cs in the middle of XFER SHALL NOT abort the transfer; the ack is still issued.
REQ-027 s_ack outside XFER SHALL be ignored.
REQ-028 The arbiter SHALL add exactly 2 cycles over the direct path: the registered request and the registered ack.

Reset
REQ-029 While reset is high, all outputs and state SHALL be 0, asynchronously: state=IDLE, s_cs=0, s_* =0, mN_ack=0, mN_err=0, mN_rdata=0, gnt_id=0, busy=0, tmo_cnt=0.
REQ-030 last_gnt SHALL reset to 1, so requester 0 wins the first tie.
REQ-031 A reset during XFER SHALL drop s_cs immediately with no ack issued, and the state SHALL be IDLE on release.

Verification
REQ-032 Single write: m0_cs=1, wr=1, addr=8'h04, wdata=32'h0000_00A5; s_ack after 3 cycles. Required: s_cs high for 3 cycles with s_addr=8'h04, then m0_ack=1 for 1 cycle, err=0, busy back to 0.
REQ-033 Tie after reset: m0_cs=m1_cs=1. Required: m0 served first (gnt_id=0), then m1 granted from the next IDLE (gnt_id=1), then a repeated tie grants m0.
REQ-034 Lock: m1 read with lock=1, s_rdata=32'h1234_5678, then m0_cs held high and m1 issues a second read. Required: m1_rdata=32'h1234_5678, the second m1 read is served before m0, and m0 is served only after m1_lock=0.
REQ-035 Timeout, TMO_CYC=4, s_ack never asserted. Required: s_cs high for 4 cycles, m0_ack=1, m0_err=1, m0_rdata=32'hFFFF_FFFF.
REQ-036 Boundary cases: s_ack on the timeout cycle gives err=0. Asserting reset in the 2nd XFER cycle drops s_cs the same cycle, gives no ack, and leaves state IDLE after release.
